fetch_prefetch_unit: RTL and testbench

Front end of the pipelined MIPS core, directly upstream of the IF/ID register. Owns the fetch PC and issues single-outstanding requests to a multi-cycle instruction memory over a req/ack handshake. Buffers returned instructions with their PC+4 in a small show-ahead FIFO, and presents them to IF/ID with valid/stall flow control. Redirects from branch/jump resolution in ID flush the buffer and restart fetch.

---
 rtl/fetch_prefetch_unit_pkg.sv | 12 +
 rtl/fetch_prefetch_unit_fifo.sv | 51 +++++
 rtl/fetch_prefetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and constants for the fetch/prefetch front end.
package fetch_prefetch_unit_pkg;
    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Show-ahead synchronous FIFO holding {pc_plus4, instruction} pairs.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    // Head is forced to zero when empty so stale entries never leak out.
    assign rdata = empty ? '0 : mem[rd_ptr];
    assign count = cnt;
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch PC owner: single-outstanding imem requests feeding a show-ahead buffer to IF/ID.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       stall,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_ack,
    input  logic [INST_W-1:0]          imem_rdata,
    output logic                       inst_valid,
    output logic [INST_W-1:0]          instruction,
    output logic [ADDR_W-1:0]          pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output fetch_state_e               dbg_state
);
    // Handshakes: imem_req/imem_addr are held until the cycle imem_ack=1 completes the
    // transfer (ack without req is ignored); toward IF/ID the head entry is transferred
    // in any cycle with inst_valid=1 and stall=0.
    localparam int               CNT_W    = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_state_e      state, state_n;
    logic [ADDR_W-1:0] fpc, fpc_n;
    logic              req_r, req_n;
    logic [ADDR_W-1:0] addr_r, addr_n;

    logic              ack_v;
    logic [ADDR_W-1:0] redirect_word;
    logic [ADDR_W-1:0] addr_plus4;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  cnt_after_ack;
    logic [CNT_W-1:0]  cnt_after_pop;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              flush;
    logic [63:0]       head;
    logic              unused_redirect_lsbs;

    assign ack_v                = imem_ack && req_r;
    assign redirect_word        = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign addr_plus4           = addr_r + PC_STEP;
    assign cnt_after_ack        = count + CNT_W'(1) - CNT_W'(pop);
    assign cnt_after_pop        = count - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            fpc    <= RESET_PC;
            req_r  <= 1'b0;
            addr_r <= RESET_PC;
        end else begin
            state  <= state_n;
            fpc    <= fpc_n;
            req_r  <= req_n;
            addr_r <= addr_n;
        end
    end

    always_comb begin
        state_n = state;
        fpc_n   = fpc;
        req_n   = req_r;
        addr_n  = addr_r;
        unique case (state)
            ST_IDLE: begin
                if (redirect) begin
                    fpc_n   = redirect_word;
                    addr_n  = redirect_word;
                    req_n   = 1'b1;
                    state_n = ST_WAIT;
                end else if (count < FULL_CNT) begin
                    addr_n  = fpc;
                    req_n   = 1'b1;
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    fpc_n = redirect_word;
                    if (ack_v) begin
                        addr_n = redirect_word;
                    end else begin
                        // Old request is still in flight; its response must be swallowed.
                        state_n = ST_DISCARD;
                    end
                end else if (ack_v) begin
                    fpc_n = addr_plus4;
                    if (cnt_after_ack < FULL_CNT) begin
                        addr_n = addr_plus4;
                    end else begin
                        req_n   = 1'b0;
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (redirect) begin
                    fpc_n = redirect_word;
                    if (ack_v) begin
                        addr_n  = redirect_word;
                        state_n = ST_WAIT;
                    end
                end else if (ack_v) begin
                    if (cnt_after_pop < FULL_CNT) begin
                        addr_n  = fpc;
                        state_n = ST_WAIT;
                    end else begin
                        req_n   = 1'b0;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    always_comb begin
        flush = redirect;
        push  = (state == ST_WAIT) && ack_v && !redirect;
        pop   = inst_valid && !stall && !redirect;
    end

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata ({addr_plus4, imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .count (count)
    );

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign inst_valid  = !fifo_empty;
    assign instruction = head[31:0];
    assign pc_plus4    = head[63:32];
    assign occupancy   = count;
    assign dbg_state   = state;
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: vector table, redirect/reset sequences, stall scoreboard.
module tb_fetch_prefetch_unit;
    import fetch_prefetch_unit_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         stall;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;
    logic         inst_valid;
    logic [31:0]  instruction;
    logic [31:0]  pc_plus4;
    logic [2:0]   occupancy;
    fetch_state_e dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .instruction(instruction), .pc_plus4(pc_plus4),
        .occupancy(occupancy), .dbg_state(dbg_state)
    );

    typedef struct {
        logic        rst;
        logic        redirect;
        logic [31:0] rpc;
        logic        stall;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
        logic [2:0]  e_occ;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_inst,
                             input logic [31:0] e_pc4, input logic [2:0] e_occ);
        cmp({tag, ".imem_req"},    {63'd0, imem_req},   {63'd0, e_req});
        cmp({tag, ".imem_addr"},   {32'd0, imem_addr},  {32'd0, e_addr});
        cmp({tag, ".inst_valid"},  {63'd0, inst_valid}, {63'd0, e_valid});
        cmp({tag, ".instruction"}, {32'd0, instruction}, {32'd0, e_inst});
        cmp({tag, ".pc_plus4"},    {32'd0, pc_plus4},   {32'd0, e_pc4});
        cmp({tag, ".occupancy"},   {61'd0, occupancy},  {61'd0, e_occ});
    endtask

    // Drive one cycle of inputs from the negedge, then step to the next negedge.
    task automatic apply(input logic r, input logic rd, input logic [31:0] rpc, input logic st,
                         input logic ak, input logic [31:0] rdat);
        rst = r; redirect = rd; redirect_pc = rpc; stall = st; imem_ack = ak; imem_rdata = rdat;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                                input logic st, input logic ak, input logic q,
                                input logic [31:0] a, input logic v, input logic [31:0] i,
                                input logic [31:0] p, input logic [2:0] o);
        vec_t t;
        t.rst = r; t.redirect = rd; t.rpc = rpc; t.stall = st; t.ack = ak;
        t.e_req = q; t.e_addr = a; t.e_valid = v; t.e_inst = i; t.e_pc4 = p; t.e_occ = o;
        return t;
    endfunction

    initial begin
        int got;
        //            rst   redir rpc    stall ack   | req   addr      valid inst          pc4       occ
        vecs[0]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,        32'h0,  3'd0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0,        32'h0,  3'd0);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h4,  1'b1, 32'hA5A50000, 32'h4,  3'd1);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'hA5A50004, 32'h8,  3'd1);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'hA5A50008, 32'hC,  3'd1);
        vecs[5]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'hA5A5000C, 32'h10, 3'd1);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,        32'h0,  3'd0);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0,        32'h0,  3'd0);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h4,  1'b1, 32'hA5A50000, 32'h4,  3'd1);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'hA5A50000, 32'h4,  3'd2);
        vecs[10] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hC,  1'b1, 32'hA5A50000, 32'h4,  3'd3);
        vecs[11] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'hC,  1'b1, 32'hA5A50000, 32'h4,  3'd4);
        vecs[12] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hC,  1'b1, 32'hA5A50000, 32'h4,  3'd4);
        vecs[13] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hC,  1'b1, 32'hA5A50000, 32'h4,  3'd4);
        vecs[14] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hC,  1'b1, 32'hA5A50004, 32'h8,  3'd3);
        vecs[15] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hA5A50008, 32'hC,  3'd2);
        vecs[16] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'hA5A5000C, 32'h10, 3'd2);
        vecs[17] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'hA5A50010, 32'h14, 3'd1);
        vecs[18] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hA5A50010, 32'h14, 3'd1);

        do_reset();
        for (int i = 0; i < NV; i++) begin
            check_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                      vecs[i].e_inst, vecs[i].e_pc4, vecs[i].e_occ);
            apply(vecs[i].rst, vecs[i].redirect, vecs[i].rpc, vecs[i].stall, vecs[i].ack,
                  vecs[i].e_addr ^ K);
        end

        // Redirect while a slow response is outstanding: that response must be swallowed.
        do_reset();
        check_out("t3_c0", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_out("t3_c1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0 ^ K);
        check_out("t3_c2", 1'b1, 32'h4, 1'b1, 32'hA5A50000, 32'h4, 3'd1);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4 ^ K);
        check_out("t3_c3", 1'b1, 32'h8, 1'b1, 32'hA5A50004, 32'h8, 3'd1);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8 ^ K);
        check_out("t3_c4", 1'b1, 32'hC, 1'b1, 32'hA5A50008, 32'hC, 3'd1);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC ^ K);
        check_out("t3_c5", 1'b1, 32'h10, 1'b1, 32'hA5A5000C, 32'h10, 3'd1);
        apply(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        check_out("t3_c6", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 3'd0);
        cmp("t3_state_discard", {62'd0, dbg_state}, {62'd0, ST_DISCARD});
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_out("t3_c7", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 3'd0);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10 ^ K);
        check_out("t3_c8", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 3'd0);
        cmp("t3_state_wait", {62'd0, dbg_state}, {62'd0, ST_WAIT});
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100 ^ K);
        check_out("t3_c9", 1'b1, 32'h104, 1'b1, 32'hA5A50100, 32'h104, 3'd1);

        // Redirect coincident with ack, address wrap, then reset during a pending request.
        do_reset();
        check_out("t4_c0", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_out("t4_c1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0 ^ K);
        check_out("t4_c2", 1'b1, 32'h4, 1'b1, 32'hA5A50000, 32'h4, 3'd1);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4 ^ K);
        check_out("t4_c3", 1'b1, 32'h8, 1'b1, 32'hA5A50000, 32'h4, 3'd2);
        apply(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h8 ^ K);
        check_out("t4_c4", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 3'd0);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200 ^ K);
        check_out("t4_c5", 1'b1, 32'h204, 1'b1, 32'hA5A50200, 32'h204, 3'd1);
        apply(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'h204 ^ K);
        check_out("t5_c6", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 3'd0);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC ^ K);
        check_out("t5_c7", 1'b1, 32'h0, 1'b1, 32'h5A5A_FFFC, 32'h0, 3'd1);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0 ^ K);
        check_out("t5_c8", 1'b1, 32'h4, 1'b1, 32'h5A5A_FFFC, 32'h0, 3'd2);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_out("t5_c9", 1'b1, 32'h4, 1'b1, 32'hA5A50000, 32'h4, 3'd1);
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4 ^ K);
        check_out("t6_c10", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
        cmp("t6_state_idle", {62'd0, dbg_state}, {62'd0, ST_IDLE});
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        check_out("t6_c11", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0 ^ K);
        check_out("t6_c12", 1'b1, 32'h4, 1'b1, 32'hA5A50000, 32'h4, 3'd1);

        // Zero-wait memory with random stall: every word must arrive once, in order.
        do_reset();
        for (int i = 0; i < 16; i++) exp_q.push_back({32'(i * 4 + 4), 32'(i * 4) ^ K});
        got = 0;
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
            stall      = ($urandom_range(0, 1) == 1);
            imem_ack   = imem_req;
            imem_rdata = imem_addr ^ K;
            if (inst_valid && !stall) begin
                cmp($sformatf("sb_word%0d", got), {pc_plus4, instruction}, exp_q.pop_front());
                got++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        cmp("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
